ssd_display_scheduler: RTL and testbench

Round-robin scheduler that time-shares one N-digit seven-segment display between R requesters. Each requester presents a packed hex-digit word plus a request. The block grants one requester at a time, latches its digits, and drives the `numbers` bus of the multiplexed SSD driver for a fixed hold time. It then signals completion and moves on. It sits between system status sources (counters, debug registers, error codes) and the SSD driver; it never touches segments or anodes.

---
 rtl/ssd_display_scheduler.sv | 141 ++++++++++++++
 tb/tb_ssd_display_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ssd_display_scheduler.sv
// Round-robin scheduler time-sharing one N-digit seven-segment display between R requesters.
// Define SSD_SCHED_GAP_EN to blank the display for GAP cycles between consecutive slots.
module ssd_display_scheduler #(
    parameter int N    = 4,
    parameter int R    = 3,
    parameter int HOLD = 750,
    parameter int GAP  = 75
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [R-1:0]     req,
    input  logic [R*N*4-1:0] data,
    output logic [R-1:0]     grant,
    output logic [R-1:0]     done,
    output logic [N*4-1:0]   numbers,
    output logic             blank,
    output logic             active
);
    localparam int DW = N * 4;
    localparam int IW = $clog2(R);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   win;
    logic [IW-1:0]   next_ptr;
    logic [R-1:0]    win_oh;
    logic [R-1:0]    owner_oh;
    logic            any_req;
    logic            take;
    logic            last;

`ifdef SSD_SCHED_GAP_EN
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    logic [GW-1:0]   gcnt;
    logic            gap_last;
    assign gap_last = (gcnt == GAP_LAST);
`else
    assign blank = 1'b0;
`endif

    assign last     = (cnt == HOLD_LAST);
    assign next_ptr = (win == IW'(R - 1)) ? '0 : win + 1'b1;
    assign win_oh   = {{(R-1){1'b0}}, 1'b1} << win;
    assign owner_oh = {{(R-1){1'b0}}, 1'b1} << owner;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % R]) begin
                any_req = 1'b1;
                win     = IW'((int'(ptr) + k) % R);
            end
        end
    end

    // take: a new slot starts on the coming edge.
    always_comb begin
        take = 1'b0;
        case (state)
            ST_IDLE: take = any_req;
`ifdef SSD_SCHED_GAP_EN
            ST_SHOW: take = 1'b0;
            ST_GAP:  take = gap_last && any_req;
`else
            ST_SHOW: take = last && any_req;
`endif
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            owner   <= '0;
            grant   <= '0;
            done    <= '0;
            numbers <= '0;
            active  <= 1'b0;
`ifdef SSD_SCHED_GAP_EN
            gcnt    <= '0;
            blank   <= 1'b0;
`endif
        end else begin
            grant <= '0;
            done  <= '0;
            if (state == ST_SHOW && last)
                done <= owner_oh;
            if (take) begin
                grant   <= win_oh;
                numbers <= data[win*DW +: DW];
                owner   <= win;
                ptr     <= next_ptr;
                active  <= 1'b1;
                cnt     <= '0;
                state   <= ST_SHOW;
`ifdef SSD_SCHED_GAP_EN
                blank   <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_SHOW: begin
                        if (last) begin
                            active <= 1'b0;
`ifdef SSD_SCHED_GAP_EN
                            state  <= ST_GAP;
                            blank  <= 1'b1;
                            gcnt   <= '0;
`else
                            state  <= ST_IDLE;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef SSD_SCHED_GAP_EN
                    ST_GAP: begin
                        if (gap_last) begin
                            state <= ST_IDLE;
                            blank <= 1'b0;
                        end else begin
                            gcnt <= gcnt + 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Directed bench for ssd_display_scheduler with N=4, R=3, HOLD=8, GAP=2.
module tb_ssd_display_scheduler;
    localparam int N    = 4;
    localparam int R    = 3;
    localparam int HOLD = 8;
    localparam int GAP  = 2;

    logic            clk;
    logic            reset;
    logic [R-1:0]    req;
    logic [R*N*4-1:0] data;
    logic [R-1:0]    grant;
    logic [R-1:0]    done;
    logic [N*4-1:0]  numbers;
    logic            blank;
    logic            active;

    int checks;
    int failures;

    ssd_display_scheduler #(.N(N), .R(R), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data    (data),
        .grant   (grant),
        .done    (done),
        .numbers (numbers),
        .blank   (blank),
        .active  (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Remaining HOLD-1 cycles of a slot after its grant cycle.
    task automatic expect_show(input string tag, input logic [15:0] num);
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            check({tag, "_active"}, 32'(active), 32'd1);
            check({tag, "_numbers"}, 32'(numbers), 32'(num));
            check({tag, "_grant"}, 32'(grant), 32'd0);
            check({tag, "_done"}, 32'(done), 32'd0);
        end
    endtask

    // Slot end followed either by the next grant or by IDLE (grant_oh = 0).
    task automatic expect_handoff(input string tag, input logic [2:0] done_oh, input logic [2:0] grant_oh,
                                  input logic [15:0] old_num, input logic [15:0] new_num);
`ifdef SSD_SCHED_GAP_EN
        tick();
        check({tag, "_done"}, 32'(done), 32'(done_oh));
        check({tag, "_blank0"}, 32'(blank), 32'd1);
        check({tag, "_active0"}, 32'(active), 32'd0);
        check({tag, "_grant0"}, 32'(grant), 32'd0);
        check({tag, "_num0"}, 32'(numbers), 32'(old_num));
        tick();
        check({tag, "_done1"}, 32'(done), 32'd0);
        check({tag, "_blank1"}, 32'(blank), 32'd1);
        check({tag, "_num1"}, 32'(numbers), 32'(old_num));
        tick();
        check({tag, "_grant"}, 32'(grant), 32'(grant_oh));
        check({tag, "_done2"}, 32'(done), 32'd0);
        check({tag, "_blank2"}, 32'(blank), 32'd0);
        check({tag, "_numbers"}, 32'(numbers), 32'(new_num));
        check({tag, "_active"}, 32'(active), 32'(grant_oh != 3'b000));
`else
        tick();
        check({tag, "_done"}, 32'(done), 32'(done_oh));
        check({tag, "_grant"}, 32'(grant), 32'(grant_oh));
        check({tag, "_numbers"}, 32'(numbers), 32'(new_num));
        check({tag, "_active"}, 32'(active), 32'(grant_oh != 3'b000));
        check({tag, "_blank"}, 32'(blank), 32'd0);
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = '0;
        data     = '0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_numbers", 32'(numbers), 32'd0);
        check("rst_blank", 32'(blank), 32'd0);
        check("rst_active", 32'(active), 32'd0);

        // Request raised while reset is still high: reset dominates.
        req         = 3'b001;
        data[15:0]  = 16'h5678;
        tick();
        check("rstreq_grant", 32'(grant), 32'd0);
        check("rstreq_numbers", 32'(numbers), 32'd0);
        check("rstreq_active", 32'(active), 32'd0);
        reset = 1'b0;
        tick();
        check("rel_grant", 32'(grant), 32'b001);
        check("rel_numbers", 32'(numbers), 32'h5678);
        check("rel_active", 32'(active), 32'd1);
        req = '0;
        expect_show("r0", 16'h5678);
        expect_handoff("r0_end", 3'b001, 3'b000, 16'h5678, 16'h5678);
        tick();
        check("r0_idle_done", 32'(done), 32'd0);
        check("r0_idle_active", 32'(active), 32'd0);

        // Single request from requester 1; it drops req and changes data after grant.
        tick();
        tick();
        req          = 3'b010;
        data[31:16]  = 16'h1234;
        tick();
        check("t1_grant", 32'(grant), 32'b010);
        check("t1_numbers", 32'(numbers), 32'h1234);
        check("t1_active", 32'(active), 32'd1);
        req          = '0;
        data[31:16]  = 16'hFFFF;
        expect_show("t1", 16'h1234);
        expect_handoff("t1_end", 3'b010, 3'b000, 16'h1234, 16'h1234);
        tick();
        check("t1_idle_done", 32'(done), 32'd0);
        check("t1_idle_grant", 32'(grant), 32'd0);
        check("t1_idle_numbers", 32'(numbers), 32'h1234);
        check("t1_idle_active", 32'(active), 32'd0);

        // All three requesting continuously after a reset: order 0,1,2,0.
        reset = 1'b1;
        tick();
        check("t2_rst_numbers", 32'(numbers), 32'd0);
        reset = 1'b0;
        data  = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        req   = 3'b111;
        tick();
        check("t2_g0_grant", 32'(grant), 32'b001);
        check("t2_g0_numbers", 32'(numbers), 32'hAAAA);
        expect_show("t2_s0", 16'hAAAA);
        expect_handoff("t2_h01", 3'b001, 3'b010, 16'hAAAA, 16'hBBBB);
        expect_show("t2_s1", 16'hBBBB);
        expect_handoff("t2_h12", 3'b010, 3'b100, 16'hBBBB, 16'hCCCC);
        expect_show("t2_s2", 16'hCCCC);
        expect_handoff("t2_h20", 3'b100, 3'b001, 16'hCCCC, 16'hAAAA);

        // Only requester 2 remains; abort its slot with reset at counter 4.
        req = 3'b100;
        expect_show("t4_s0", 16'hAAAA);
        expect_handoff("t4_h02", 3'b001, 3'b100, 16'hAAAA, 16'hCCCC);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_hold_active", 32'(active), 32'd1);
        end
        reset = 1'b1;
        req   = 3'b101;
        tick();
        check("t4_abort_numbers", 32'(numbers), 32'd0);
        check("t4_abort_active", 32'(active), 32'd0);
        check("t4_abort_done", 32'(done), 32'd0);
        check("t4_abort_grant", 32'(grant), 32'd0);
        check("t4_abort_blank", 32'(blank), 32'd0);
        reset = 1'b0;
        tick();
        check("t4_regrant", 32'(grant), 32'b001);
        check("t4_regrant_numbers", 32'(numbers), 32'hAAAA);
        check("t4_regrant_done", 32'(done), 32'd0);
        req = '0;
        expect_show("t4_s0b", 16'hAAAA);
        expect_handoff("t4_end", 3'b001, 3'b000, 16'hAAAA, 16'hAAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
